// File: rtl/el2_dccm_mem_init_if.sv
// ---------------------------------------------------------------------------
// el2_dccm_mem_init_if
// Purpose : per-bank DCCM SRAM control bundle. It is used twice: once for the
//           traffic coming from the DCCM controller and once for the traffic
//           going to the SRAM macros.
// Signals : clken   [NB]        per-bank clock enable
//           wren    [NB]        per-bank write enable
//           addr    [NB*ROW_W]  per-bank row address, bank 0 in the LSBs
//           wr_data [NB*32]     per-bank write data, bank 0 in the LSBs
//           wr_ecc  [NB*7]      per-bank SECDED check bits, bank 0 in the LSBs
// Modports: master drives the bundle, slave receives it.
// ---------------------------------------------------------------------------
interface el2_dccm_mem_init_if #(
   parameter int NB    = 4,
   parameter int ROW_W = 11
);
   logic [NB-1:0]       clken;
   logic [NB-1:0]       wren;
   logic [NB*ROW_W-1:0] addr;
   logic [NB*32-1:0]    wr_data;
   logic [NB*7-1:0]     wr_ecc;

   modport master (output clken, output wren, output addr, output wr_data, output wr_ecc);
   modport slave  (input  clken, input  wren, input  addr, input  wr_data, input  wr_ecc);
endinterface

// File: rtl/el2_dccm_mem_init.sv
// ---------------------------------------------------------------------------
// el2_dccm_mem_init
// Purpose : sits between the DCCM controller and the DCCM SRAM macros. After
//           reset, or when init_req is seen in DONE, it writes every row of
//           every bank with zero data and zero ECC so that first reads cannot
//           raise spurious ECC errors. Once finished it is a zero-latency
//           pass-through for core traffic.
// Ports   : clk            core clock
//           rst            asynchronous active-high reset
//           init_req       re-run initialization (honoured only in DONE)
//           core           slave bundle from the DCCM controller
//           sram           master bundle to the SRAM macros
//           init_busy      SRAM is owned by init, core must stall
//           init_done      memory is initialized
//           init_collision one-cycle pulse after a core access was dropped
// Config  : RV_DCCM_MEM_INIT_EN defined   -> FSM and row counter are built.
//           RV_DCCM_MEM_INIT_EN undefined -> pure wire pass-through,
//                                            init_done=1, init_busy=0.
// ---------------------------------------------------------------------------
module el2_dccm_mem_init #(
   parameter int DCCM_NUM_BANKS = 4,
   parameter int DCCM_ROWS      = 2048,
   parameter int ROW_W          = $clog2(DCCM_ROWS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        init_req,
   el2_dccm_mem_init_if.slave          core,
   el2_dccm_mem_init_if.master         sram,
   output logic                        init_busy,
   output logic                        init_done,
   output logic                        init_collision
);

`ifdef RV_DCCM_MEM_INIT_EN

   typedef enum logic [1:0] {
      WAIT = 2'd0,
      INIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DCCM_ROWS - 1);

   state_t            state;
   state_t            state_next;
   logic [ROW_W-1:0]  row_cnt;
   logic [ROW_W-1:0]  row_cnt_next;
   logic              collision_q;

   logic [DCCM_NUM_BANKS-1:0]       clken_mux;
   logic [DCCM_NUM_BANKS-1:0]       wren_mux;
   logic [DCCM_NUM_BANKS*ROW_W-1:0] addr_mux;
   logic [DCCM_NUM_BANKS*32-1:0]    data_mux;
   logic [DCCM_NUM_BANKS*7-1:0]     ecc_mux;

   // Status flags come straight from the state register so the core sees no
   // combinational path from any input to its stall signal.
   assign init_busy      = (state != DONE);
   assign init_done      = (state == DONE);
   assign init_collision = collision_q;

   // State, row counter and collision flag. A core enable seen while the
   // SRAM is owned by init is dropped; the flag reports it one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= WAIT;
         row_cnt     <= '0;
         collision_q <= 1'b0;
      end else begin
         state       <= state_next;
         row_cnt     <= row_cnt_next;
         collision_q <= init_busy & (|core.clken);
      end
   end

   // Next-state logic. WAIT always leaves on the first edge out of reset.
   // The counter is zeroed whenever INIT is about to be entered and stops at
   // the last row instead of wrapping, since that edge is the exit to DONE.
   always_comb begin
      state_next   = state;
      row_cnt_next = row_cnt;
      case (state)
         WAIT: begin
            state_next   = INIT;
            row_cnt_next = '0;
         end
         INIT: begin
            if (row_cnt == LAST_ROW) begin
               state_next   = DONE;
               row_cnt_next = '0;
            end else begin
               row_cnt_next = row_cnt + ROW_W'(1);
            end
         end
         DONE: begin
            if (init_req) begin
               state_next   = INIT;
               row_cnt_next = '0;
            end
         end
         default: begin
            state_next   = WAIT;
            row_cnt_next = '0;
         end
      endcase
   end

   // SRAM port mux. WAIT parks the macros, INIT writes the same zero row into
   // every bank, DONE forwards the core bundle untouched. A core access that
   // coincides with init_req in DONE is therefore still forwarded.
   always_comb begin
      clken_mux = '0;
      wren_mux  = '0;
      addr_mux  = '0;
      data_mux  = '0;
      ecc_mux   = '0;
      case (state)
         INIT: begin
            clken_mux = '1;
            wren_mux  = '1;
            addr_mux  = {DCCM_NUM_BANKS{row_cnt}};
         end
         DONE: begin
            clken_mux = core.clken;
            wren_mux  = core.wren;
            addr_mux  = core.addr;
            data_mux  = core.wr_data;
            ecc_mux   = core.wr_ecc;
         end
         default: begin
            clken_mux = '0;
         end
      endcase
   end

   assign sram.clken   = clken_mux;
   assign sram.wren    = wren_mux;
   assign sram.addr    = addr_mux;
   assign sram.wr_data = data_mux;
   assign sram.wr_ecc  = ecc_mux;

`else

   // Without the init engine the block is just wires; clock, reset and the
   // request input have nothing to drive.
   logic unused_inputs;
   assign unused_inputs = ^{clk, rst, init_req};

   assign sram.clken     = core.clken;
   assign sram.wren      = core.wren;
   assign sram.addr      = core.addr;
   assign sram.wr_data   = core.wr_data;
   assign sram.wr_ecc    = core.wr_ecc;
   assign init_busy      = 1'b0;
   assign init_done      = 1'b1;
   assign init_collision = 1'b0;

`endif

endmodule

// File: tb/tb_el2_dccm_mem_init.sv
// ---------------------------------------------------------------------------
// tb_el2_dccm_mem_init
// Purpose : directed self-checking bench for el2_dccm_mem_init with four
//           banks of four rows. With RV_DCCM_MEM_INIT_EN defined it walks the
//           init sequence, collision, pass-through, re-init and reset during
//           init; otherwise it checks the pure pass-through build.
// ---------------------------------------------------------------------------
module tb_el2_dccm_mem_init;

   localparam int NB    = 4;
   localparam int ROWS  = 4;
   localparam int RW    = 2;

   logic clk;
   logic rst;
   logic init_req;
   logic init_busy;
   logic init_done;
   logic init_collision;

   int total;
   int bad;

   logic [3:0]   stim_clken;
   logic [3:0]   stim_wren;
   logic [7:0]   stim_addr;
   logic [127:0] stim_data;
   logic [27:0]  stim_ecc;

   el2_dccm_mem_init_if #(.NB(NB), .ROW_W(RW)) core_bus ();
   el2_dccm_mem_init_if #(.NB(NB), .ROW_W(RW)) sram_bus ();

   el2_dccm_mem_init #(
      .DCCM_NUM_BANKS (NB),
      .DCCM_ROWS      (ROWS),
      .ROW_W          (RW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .init_req       (init_req),
      .core           (core_bus),
      .sram           (sram_bus),
      .init_busy      (init_busy),
      .init_done      (init_done),
      .init_collision (init_collision)
   );

   // Free-running clock; all checks happen at or just after the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive the core bundle and remember what was driven.
   task automatic applyStimulus(input logic [3:0] clken, input logic [3:0] wren,
                                input logic [7:0] addr, input logic [127:0] data,
                                input logic [27:0] ecc);
      stim_clken       = clken;
      stim_wren        = wren;
      stim_addr        = addr;
      stim_data        = data;
      stim_ecc         = ecc;
      core_bus.clken   = clken;
      core_bus.wren    = wren;
      core_bus.addr    = addr;
      core_bus.wr_data = data;
      core_bus.wr_ecc  = ecc;
   endtask

   // One comparison: count it, and on mismatch count and report it.
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expect the SRAM bundle to show one init row on every bank.
   task automatic checkInitRow(input string tag, input logic [7:0] exp_addr);
      checkOutput({tag, "_clken"}, sram_bus.clken, 4'hF);
      checkOutput({tag, "_wren"},  sram_bus.wren,  4'hF);
      checkOutput({tag, "_addr"},  sram_bus.addr,  exp_addr);
      checkOutput({tag, "_data"},  sram_bus.wr_data, 128'h0);
      checkOutput({tag, "_ecc"},   sram_bus.wr_ecc,  28'h0);
      checkOutput({tag, "_busy"},  init_busy, 1'b1);
      checkOutput({tag, "_done"},  init_done, 1'b0);
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      init_req = 1'b0;
      applyStimulus(4'h0, 4'h0, 8'h00, 128'h0, 28'h0);

`ifdef RV_DCCM_MEM_INIT_EN
      $display("[TB] init engine build");
      repeat (2) @(negedge clk);
      checkOutput("rst_busy",  init_busy, 1'b1);
      checkOutput("rst_done",  init_done, 1'b0);
      checkOutput("rst_coll",  init_collision, 1'b0);
      checkOutput("rst_clken", sram_bus.clken, 4'h0);
      checkOutput("rst_wren",  sram_bus.wren, 4'h0);
      checkOutput("rst_addr",  sram_bus.addr, 8'h00);

      // Release reset; the next rising edge is E0 and presents row 0.
      rst = 1'b0;
      @(negedge clk);
      checkInitRow("row0", 8'h00);
      @(negedge clk);
      checkInitRow("row1", 8'h55);
      // Core read on bank 0 during row 1 must be dropped.
      applyStimulus(4'b0001, 4'b0000, 8'h03, 128'h5, 28'h0);
      #1;
      checkOutput("coll_wren", sram_bus.wren, 4'hF);
      checkOutput("coll_addr", sram_bus.addr, 8'h55);
      checkOutput("coll_pre",  init_collision, 1'b0);
      @(negedge clk);
      checkOutput("coll_pulse", init_collision, 1'b1);
      checkOutput("row2_addr",  sram_bus.addr, 8'hAA);
      applyStimulus(4'h0, 4'h0, 8'h00, 128'h0, 28'h0);
      @(negedge clk);
      checkOutput("coll_end",  init_collision, 1'b0);
      checkOutput("row3_addr", sram_bus.addr, 8'hFF);
      checkOutput("row3_done", init_done, 1'b0);
      @(negedge clk);
      checkOutput("done_done", init_done, 1'b1);
      checkOutput("done_busy", init_busy, 1'b0);
      checkOutput("done_idle", sram_bus.clken, 4'h0);
`else
      $display("[TB] pass-through build");
      #1;
      checkOutput("rst_busy", init_busy, 1'b0);
      checkOutput("rst_done", init_done, 1'b1);
      checkOutput("rst_coll", init_collision, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'($urandom), 4'($urandom), 8'($urandom),
                       {$urandom, $urandom, $urandom, $urandom}, 28'($urandom));
         #1;
         checkOutput("rrst_clken", sram_bus.clken,   stim_clken);
         checkOutput("rrst_wren",  sram_bus.wren,    stim_wren);
         checkOutput("rrst_addr",  sram_bus.addr,    stim_addr);
         checkOutput("rrst_data",  sram_bus.wr_data, stim_data);
         checkOutput("rrst_ecc",   sram_bus.wr_ecc,  stim_ecc);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("run_busy", init_busy, 1'b0);
      checkOutput("run_done", init_done, 1'b1);
`endif

      // Bank 2 write of DEADBEEF/5A at row 3, other banks carry their own values.
      applyStimulus(4'b1101, 4'b1100, 8'h39,
                    {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111},
                    {7'h7F, 7'h5A, 7'h02, 7'h01});
      #1;
      checkOutput("pt_clken", sram_bus.clken, 4'b1101);
      checkOutput("pt_wren",  sram_bus.wren,  4'b1100);
      checkOutput("pt_addr",  sram_bus.addr,  8'b00_11_10_01);
      checkOutput("pt_data",  sram_bus.wr_data,
                  128'h33333333_DEADBEEF_22222222_11111111);
      checkOutput("pt_ecc",   sram_bus.wr_ecc, 28'b1111111_1011010_0000010_0000001);
      @(negedge clk);
      checkOutput("pt_coll",  init_collision, 1'b0);

`ifdef RV_DCCM_MEM_INIT_EN
      // init_req together with a core write to row 2: the write goes through.
      applyStimulus(4'b0001, 4'b0001, 8'h02, 128'hABCD, 28'h11);
      init_req = 1'b1;
      #1;
      checkOutput("req_clken", sram_bus.clken, 4'b0001);
      checkOutput("req_addr",  sram_bus.addr,  8'h02);
      checkOutput("req_data",  sram_bus.wr_data, 128'hABCD);
      checkOutput("req_busy",  init_busy, 1'b0);
      @(negedge clk);
      checkInitRow("re_row0", 8'h00);
      applyStimulus(4'h0, 4'h0, 8'h00, 128'h0, 28'h0);
      @(negedge clk);
      checkOutput("re_coll", init_collision, 1'b0);
      checkInitRow("re_row1", 8'h55);
      @(negedge clk);
      checkInitRow("re_row2", 8'hAA);
      @(negedge clk);
      checkInitRow("re_row3", 8'hFF);
      init_req = 1'b0;
      @(negedge clk);
      checkOutput("re_done", init_done, 1'b1);
      checkOutput("re_busy", init_busy, 1'b0);

      // Start another init and reset it during row 2.
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
      checkInitRow("mr_row0", 8'h00);
      @(negedge clk);
      checkInitRow("mr_row1", 8'h55);
      @(negedge clk);
      checkInitRow("mr_row2", 8'hAA);
      #1 rst = 1'b1;
      #1;
      checkOutput("mr_rst_clken", sram_bus.clken, 4'h0);
      checkOutput("mr_rst_busy",  init_busy, 1'b1);
      checkOutput("mr_rst_addr",  sram_bus.addr, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkInitRow("rr_row0", 8'h00);
      @(negedge clk);
      checkInitRow("rr_row1", 8'h55);
      @(negedge clk);
      checkInitRow("rr_row2", 8'hAA);
      @(negedge clk);
      checkInitRow("rr_row3", 8'hFF);
      @(negedge clk);
      checkOutput("rr_done", init_done, 1'b1);
      checkOutput("rr_busy", init_busy, 1'b0);
`else
      // init_req has no effect in this build.
      init_req = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("req_busy", init_busy, 1'b0);
      checkOutput("req_done", init_done, 1'b1);
      init_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'($urandom), 4'($urandom), 8'($urandom),
                       {$urandom, $urandom, $urandom, $urandom}, 28'($urandom));
         #1;
         checkOutput("rnd_clken", sram_bus.clken,   stim_clken);
         checkOutput("rnd_wren",  sram_bus.wren,    stim_wren);
         checkOutput("rnd_addr",  sram_bus.addr,    stim_addr);
         checkOutput("rnd_data",  sram_bus.wr_data, stim_data);
         checkOutput("rnd_ecc",   sram_bus.wr_ecc,  stim_ecc);
         @(negedge clk);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
